// File: rtl/irrigation_pkg.sv
// Shared definitions for the multi-zone irrigation sequencer.
// Holds the sequencer state encoding and the default timing constants
// that the top level and the fault filter build their parameters from.
package irrigation_pkg;

    // Sequencer modes: scanning for a dry zone, watering one zone,
    // holding all valves closed after a burst, or sensor fault lockout.
    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        WATER  = 2'd1,
        SETTLE = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Default burst length limit, post-burst closed gap, and number of
    // consecutive healthy cycles needed to leave the fault lockout.
    localparam int DEFAULT_MAX_ON      = 200;
    localparam int DEFAULT_SETTLE      = 16;
    localparam int DEFAULT_FAULT_CLEAR = 8;

endpackage

// File: rtl/irrigation_fault_filter.sv
// Debounce for leaving the sensor-fault lockout.
// Counts consecutive cycles with the water-level sensors agreeing while the
// sequencer sits in FAULT; any disagreement restarts the count.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   run          high while the sequencer is in FAULT
//   conflicting  water-level sensors disagree (1 = unhealthy cycle)
//   fault_clear  combinational pulse: this cycle completes the healthy run
module irrigation_fault_filter
    import irrigation_pkg::*;
#(
    parameter int FAULT_CLEAR = DEFAULT_FAULT_CLEAR
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic conflicting,
    output logic fault_clear
);

    localparam int CW = $clog2(FAULT_CLEAR + 1);

    logic [CW-1:0] healthy_cnt;

    // The pulse fires on the healthy cycle that would make the count reach
    // FAULT_CLEAR, so the sequencer leaves FAULT on that same edge.
    assign fault_clear = run && !conflicting && (healthy_cnt == CW'(FAULT_CLEAR - 1));

    // Count is held at zero outside FAULT so every lockout starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            healthy_cnt <= '0;
        end else if (!run || conflicting || fault_clear) begin
            healthy_cnt <= '0;
        end else begin
            healthy_cnt <= healthy_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/irrigation_zone_sequencer.sv
// Multi-zone irrigation sequencer.
// Scans the per-zone humidity sensors round-robin and waters at most one dry
// zone at a time, gated by water-sensor health and supply level. Each burst
// is bounded by MAX_ON cycles and followed by SETTLE closed cycles.
//
// Ports:
//   clk                       system clock
//   rst_n                     synchronous active-low reset
//   enable                    sequencer run enable
//   earth_humidity[N]         per-zone sensor, 1 = wet, 0 = dry
//   water_sensor_conflicting  water-level sensors disagree (fault)
//   low_water_level           1 = supply above the low mark
//   zone_mode[N]              per-zone actuator, 1 = sprinkler, 0 = dripper
//   valve[N]                  one-hot open valve, or all zero
//   sprinkler / dripper       pump enables, only while a valve is open
//   active_zone               zone being served or next to check
//   fault                     sensor fault latched
//   busy                      high while watering or settling
module irrigation_zone_sequencer
    import irrigation_pkg::*;
#(
    parameter int N_ZONES     = 4,
    parameter int MAX_ON      = DEFAULT_MAX_ON,
    parameter int SETTLE      = DEFAULT_SETTLE,
    parameter int FAULT_CLEAR = DEFAULT_FAULT_CLEAR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [N_ZONES-1:0]         earth_humidity,
    input  logic                       water_sensor_conflicting,
    input  logic                       low_water_level,
    input  logic [N_ZONES-1:0]         zone_mode,
    output logic [N_ZONES-1:0]         valve,
    output logic                       sprinkler,
    output logic                       dripper,
    output logic [$clog2(N_ZONES)-1:0] active_zone,
    output logic                       fault,
    output logic                       busy
);

    localparam int ZW = $clog2(N_ZONES);
    localparam int OW = $clog2(MAX_ON + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [N_ZONES-1:0] VALVE_BASE = N_ZONES'(1);

    state_t        state, state_next;
    logic [ZW-1:0] zone_next, zone_inc;
    logic [OW-1:0] on_timer, on_timer_next;
    logic [SW-1:0] settle_cnt, settle_next;
    logic          ok;
    logic          fault_clear;

    logic [N_ZONES-1:0] valve_d;
    logic               sprinkler_d, dripper_d, fault_d, busy_d;

    assign ok       = !water_sensor_conflicting && low_water_level;
    assign zone_inc = (active_zone == ZW'(N_ZONES - 1)) ? '0 : active_zone + ZW'(1);

    irrigation_fault_filter #(
        .FAULT_CLEAR (FAULT_CLEAR)
    ) u_fault_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (state == FAULT),
        .conflicting (water_sensor_conflicting),
        .fault_clear (fault_clear)
    );

    // State, zone pointer, timers and all outputs are registered together so
    // every output reflects the mode the sequencer has just entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SCAN;
            active_zone <= '0;
            on_timer    <= '0;
            settle_cnt  <= '0;
            valve       <= '0;
            sprinkler   <= 1'b0;
            dripper     <= 1'b0;
            fault       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            active_zone <= zone_next;
            on_timer    <= on_timer_next;
            settle_cnt  <= settle_next;
            valve       <= valve_d;
            sprinkler   <= sprinkler_d;
            dripper     <= dripper_d;
            fault       <= fault_d;
            busy        <= busy_d;
        end
    end

    // Mode transitions. A sensor conflict overrides everything and aborts a
    // burst without the settle gap; the zone pointer stays where it was.
    always_comb begin
        state_next    = state;
        zone_next     = active_zone;
        on_timer_next = on_timer;
        settle_next   = settle_cnt;
        if (water_sensor_conflicting) begin
            state_next = FAULT;
        end else begin
            case (state)
                SCAN: begin
                    if (enable && ok && !earth_humidity[active_zone]) begin
                        state_next    = WATER;
                        on_timer_next = '0;
                    end else if (enable) begin
                        zone_next = zone_inc;
                    end
                end
                WATER: begin
                    if (earth_humidity[active_zone] || (on_timer == OW'(MAX_ON - 1)) ||
                        !low_water_level || !enable) begin
                        state_next  = irrigation_pkg::SETTLE;
                        settle_next = '0;
                    end else begin
                        on_timer_next = on_timer + OW'(1);
                    end
                end
                irrigation_pkg::SETTLE: begin
                    // Advancing past the served zone here keeps a zone that
                    // timed out from being watered back-to-back.
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        state_next = SCAN;
                        zone_next  = zone_inc;
                    end else begin
                        settle_next = settle_cnt + SW'(1);
                    end
                end
                FAULT: begin
                    if (fault_clear) begin
                        state_next  = irrigation_pkg::SETTLE;
                        settle_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    // Output values for the mode being entered. Pump selection follows the
    // zone mode every cycle of a burst, and only while a valve is open.
    always_comb begin
        valve_d     = '0;
        sprinkler_d = 1'b0;
        dripper_d   = 1'b0;
        if (state_next == WATER) begin
            valve_d     = VALVE_BASE << zone_next;
            sprinkler_d = zone_mode[zone_next];
            dripper_d   = !zone_mode[zone_next];
        end
        fault_d = (state_next == FAULT);
        busy_d  = (state_next == WATER) || (state_next == irrigation_pkg::SETTLE);
    end

endmodule
